exec_controller: RTL and testbench
==================================

// Module: exec_controller
// PURPOSE
//  Run/step/stop sequencer for the simple pipeline CPU on the FPGA board.
//  Debounces three raw push-buttons, runs a 4-state FSM and drives the
//  pipeline clock-enable (cpu_en): free-run, single-cycle step, or stopped.
//  Also stops on the CPU halt indication and counts enabled cycles.
// PARAMETERS
//  DEB_CYCLES  500000  consecutive stable samples before a button level is accepted (10 ms @ 50 MHz)
//  PC_W        16      width of pc / bp_addr
//  CNT_W       32      width of cycle_cnt
// PORTS
//  clk        in   1      system clock; single clock domain
//  rst_n      in   1      asynchronous, active-low reset
//  btn_run    in   1      raw button, active-low, asynchronous to clk
//  btn_step   in   1      raw button, active-low, asynchronous to clk
//  btn_stop   in   1      raw button, active-low, asynchronous to clk
//  halt_in    in   1      CPU retired a halt instruction (valid only while cpu_en=1)
//  pc         in   PC_W   current PC (breakpoint compare)
//  bp_addr    in   PC_W   breakpoint address        [BREAKPOINT_EN only]
//  bp_valid   in   1      breakpoint armed          [BREAKPOINT_EN only]
//  cpu_en     out  1      pipeline clock-enable
//  state_o    out  2      FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALT
//  halted     out  1      1 while state==HALT
//  bp_hit     out  1      sticky breakpoint flag    [BREAKPOINT_EN only]
//  cycle_cnt  out  CNT_W  number of cycles with cpu_en=1
// BEHAVIOUR
//  Reset: state IDLE, cpu_en 0, halted 0, bp_hit 0, cycle_cnt 0, debounced levels 0.
//  Button path, per button: 2-FF sync, invert (pressed=1), debounce counter.
//   Accepted level changes only after DEB_CYCLES consecutive equal samples; any
//   differing sample restarts the count. 0->1 of accepted level = one-cycle press pulse.
//   Held button produces exactly one pulse; release produces none.
//  cpu_en = (state==RUN)|(state==STEP), decoded from the state register.
//   Press pulse in cycle N -> state change at N+1 -> cpu_en high from N+1.
//  Transitions (in priority order per state):
//   IDLE: run_p -> RUN; else step_p -> STEP; stop_p ignored.
//   RUN : halt_in -> HALT; else stop_p -> IDLE; run_p/step_p ignored.
//   STEP: halt_in -> HALT; else -> IDLE. cpu_en high exactly one cycle per step.
//   HALT: stop_p -> IDLE; run_p/step_p ignored. Only exit besides reset.
//  halt_in sampled only when cpu_en=1; the halting cycle itself is enabled,
//   cpu_en low from the next cycle.
//  cycle_cnt += 1 on every cycle with cpu_en=1; wraps to 0 at 2^CNT_W-1, no flag.
//  Reset mid-run: cpu_en drops immediately (async), all state as reset values;
//   a button held through reset yields a press pulse after DEB_CYCLES+2 cycles.
// CONFIGURATION
//  BREAKPOINT_EN defined: bp_addr/bp_valid/bp_hit ports exist. In RUN, when
//   bp_valid && pc==bp_addr and not the first RUN cycle after leaving IDLE,
//   state -> IDLE next cycle and bp_hit<=1. Priority: halt_in > stop_p > breakpoint.
//   First-cycle exemption lets run resume from the breakpoint PC. STEP never
//   checks the breakpoint. bp_hit clears on the next run_p or step_p accepted.
//  BREAKPOINT_EN undefined: those ports absent, no compare logic; pc unused.
// TESTING (DEB_CYCLES=4 in simulation)
//  btn_run low 3 cycles then high -> no pulse, state stays 00, cpu_en 0.
//  btn_run low 20 cycles -> one pulse, state 01, cpu_en 1 continuously, cycle_cnt increments per cycle.
//  IDLE, press step 3 times -> exactly 3 cpu_en cycles total, cycle_cnt=3, state back to 00 each time.
//  RUN, assert halt_in and stop pulse same cycle -> state 11, halted 1; run press ignored; stop press -> 00.
//  BREAKPOINT_EN, bp_addr=0x0010, pc ramps 0..: stop after pc=0x0010 cycle, bp_hit 1; run again -> pc 0x0011 reached, bp_hit 0.
//  Force cycle_cnt near max (CNT_W=4): 16 enabled cycles -> wraps to 0; rst_n low mid-RUN -> cpu_en 0 at once.

Source files
------------

// File: rtl/exec_controller.sv
// Run/step/stop sequencer: debounced buttons drive the pipeline clock-enable.
// Define BREAKPOINT_EN to add the bp_addr/bp_valid compare and bp_hit flag.
module exec_controller #(
  parameter int DEB_CYCLES = 500000,
  parameter int PC_W       = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             btn_stop,
  input  logic             halt_in,
  input  logic [PC_W-1:0]  pc,
`ifdef BREAKPOINT_EN
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_valid,
  output logic             bp_hit,
`endif
  output logic             cpu_en,
  output logic [1:0]       state_o,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  state_t state;

  logic [2:0]         btn_raw;
  logic [2:0]         s1;
  logic [2:0]         s2;
  logic [2:0]         lvl;
  logic [2:0]         press;
  logic [2:0][DW-1:0] cnt;

  logic run_p;
  logic step_p;
  logic stop_p;
  logic bp_stop;

  assign btn_raw = {btn_stop, btn_step, btn_run};
  assign {stop_p, step_p, run_p} = press;

  // Count samples that disagree with the accepted level; any agreeing
  // sample restarts the count, so only a stable new level is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      lvl   <= '0;
      press <= '0;
      cnt   <= '0;
    end else begin
      s1 <= ~btn_raw;
      s2 <= s1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DW'(DEB_CYCLES - 1)) begin
          cnt[i]   <= '0;
          lvl[i]   <= s2[i];
          press[i] <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BREAKPOINT_EN
  logic run_first;

  assign bp_stop = bp_valid && (pc == bp_addr) && !run_first;

  // The first RUN cycle is exempt so a run can resume from the breakpoint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_first <= 1'b0;
      bp_hit    <= 1'b0;
    end else begin
      run_first <= (state == IDLE) && run_p;
      if ((state == IDLE) && (run_p || step_p))
        bp_hit <= 1'b0;
      else if ((state == RUN) && !halt_in && !stop_p && bp_stop)
        bp_hit <= 1'b1;
    end
  end
`else
  logic pc_unused;

  assign pc_unused = ^pc;
  assign bp_stop   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (run_p)
            state <= RUN;
          else if (step_p)
            state <= STEP;
        end
        RUN: begin
          if (halt_in)
            state <= HALT;
          else if (stop_p)
            state <= IDLE;
          else if (bp_stop)
            state <= IDLE;
        end
        STEP: begin
          state <= halt_in ? HALT : IDLE;
        end
        HALT: begin
          if (stop_p)
            state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle_cnt <= '0;
    else if (cpu_en)
      cycle_cnt <= cycle_cnt + 1'b1;
  end

  assign cpu_en  = (state == RUN) || (state == STEP);
  assign halted  = (state == HALT);
  assign state_o = state;

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller: directed plus random button/halt traffic
// checked every cycle against a behavioural sequencer model.
module tb_exec_controller;

  localparam int DEB = 4;
  localparam int PCW = 16;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           btn_run;
  logic           btn_step;
  logic           btn_stop;
  logic           halt_in;
  logic [PCW-1:0] pc;
  logic           cpu_en;
  logic [1:0]     state_o;
  logic           halted;
  logic [CW-1:0]  cycle_cnt;
`ifdef BREAKPOINT_EN
  logic [PCW-1:0] bp_addr;
  logic           bp_valid;
  logic           bp_hit;
`endif

  always #5 clk = ~clk;

  exec_controller #(
    .DEB_CYCLES(DEB),
    .PC_W(PCW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .btn_stop(btn_stop),
    .halt_in(halt_in),
    .pc(pc),
`ifdef BREAKPOINT_EN
    .bp_addr(bp_addr),
    .bp_valid(bp_valid),
    .bp_hit(bp_hit),
`endif
    .cpu_en(cpu_en),
    .state_o(state_o),
    .halted(halted),
    .cycle_cnt(cycle_cnt)
  );

  typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;

  mode_t    m_mode;
  bit       m_first;
  bit       m_bp;
  int       m_cnt;
  int       m_pc;
  bit [2:0] m_lvl;
  bit [2:0] m_pend;
  bit [2:0] hist[$];

  int checks = 0;
  int failures = 0;
  int halt_pct = 0;
  bit force_halt = 1'b0;

  function automatic logic [1:0] code(mode_t m);
    case (m)
      M_RUN:   return 2'b01;
      M_STEP:  return 2'b10;
      M_HALT:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_first = 1'b0;
    m_bp    = 1'b0;
    m_cnt   = 0;
    m_pc    = 0;
    m_lvl   = '0;
    m_pend  = '0;
    hist.delete();
    repeat (DEB + 2) hist.push_front(3'b000);
    pc = '0;
  endtask

  // One clock: predict from the spec rules, then compare after the edge.
  task automatic tick();
    bit       en;
    bit       en_nx;
    bit       bp_cond;
    bit       all_new;
    bit [2:0] pin;
    mode_t    nxt;
    en = (m_mode == M_RUN) || (m_mode == M_STEP);
    halt_in = en && (force_halt || ($urandom_range(0, 99) < halt_pct));
    pin = ~{btn_stop, btn_step, btn_run};
    bp_cond = 1'b0;
`ifdef BREAKPOINT_EN
    bp_cond = bp_valid && (pc == bp_addr) && !m_first;
`endif
    nxt = m_mode;
    case (m_mode)
      M_IDLE: begin
        if (m_pend[0]) nxt = M_RUN;
        else if (m_pend[1]) nxt = M_STEP;
      end
      M_RUN: begin
        if (halt_in) nxt = M_HALT;
        else if (m_pend[2]) nxt = M_IDLE;
        else if (bp_cond) begin
          nxt  = M_IDLE;
          m_bp = 1'b1;
        end
      end
      M_STEP: nxt = halt_in ? M_HALT : M_IDLE;
      default: if (m_pend[2]) nxt = M_IDLE;
    endcase
    if ((m_mode == M_IDLE) && (m_pend[0] || m_pend[1])) m_bp = 1'b0;
    m_first = (m_mode == M_IDLE) && m_pend[0];
    if (en) begin
      m_cnt = (m_cnt + 1) % (1 << CW);
      m_pc++;
    end
    hist.push_front(pin);
    void'(hist.pop_back());
    for (int b = 0; b < 3; b++) begin
      all_new = 1'b1;
      for (int j = 2; j < DEB + 2; j++)
        if (hist[j][b] == m_lvl[b]) all_new = 1'b0;
      m_pend[b] = all_new && !m_lvl[b];
      if (all_new) m_lvl[b] = !m_lvl[b];
    end
    @(posedge clk);
    #1;
    m_mode = nxt;
    pc = PCW'(m_pc);
    en_nx = (m_mode == M_RUN) || (m_mode == M_STEP);
    chk("state", 32'(state_o), 32'(code(m_mode)));
    chk("cpu_en", 32'(cpu_en), 32'(en_nx));
    chk("halted", 32'(halted), 32'(m_mode == M_HALT));
    chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
`ifdef BREAKPOINT_EN
    chk("bp_hit", 32'(bp_hit), 32'(m_bp));
`endif
  endtask

  task automatic set_btn(int b, logic v);
    case (b)
      0:       btn_run  = v;
      1:       btn_step = v;
      default: btn_stop = v;
    endcase
  endtask

  task automatic press(int b, int hold, int gap);
    set_btn(b, 1'b0);
    repeat (hold) tick();
    set_btn(b, 1'b1);
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    halt_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_cpu_en", 32'(cpu_en), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_cnt", 32'(cycle_cnt), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int c0;
    int n;
    bit seen;
    rst_n    = 1'b0;
    btn_run  = 1'b1;
    btn_step = 1'b1;
    btn_stop = 1'b1;
    halt_in  = 1'b0;
    pc       = '0;
`ifdef BREAKPOINT_EN
    bp_addr  = 16'h0010;
    bp_valid = 1'b0;
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_cpu_en", 32'(cpu_en), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_cnt", 32'(cycle_cnt), 32'd0);
`ifdef BREAKPOINT_EN
    chk("reset_bp_hit", 32'(bp_hit), 32'd0);
`endif
    rst_n = 1'b1;
    model_reset();

    // Short glitch must not register.
    press(0, 3, 12);
    chk("short_press_state", 32'(state_o), 32'd0);
    chk("short_press_en", 32'(cpu_en), 32'd0);

    // Long press: free-run, counter tracks every enabled cycle.
    press(0, 20, 0);
    chk("run_state", 32'(state_o), 32'h1);
    c0 = m_cnt;
    n = $urandom_range(5, 15);
    repeat (n) tick();
    chk("run_cnt", 32'(cycle_cnt), 32'((c0 + n) % 16));
    press(2, $urandom_range(8, 20), 5);
    chk("stop_state", 32'(state_o), 32'd0);

    // Three single steps give exactly three enabled cycles.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      press(1, $urandom_range(8, 15), $urandom_range(8, 12));
      chk("step_idle", 32'(state_o), 32'd0);
    end
    chk("step_cnt", 32'(cycle_cnt), 32'd3);

    // Halt beats a stop pulse landing in the same cycle.
    press(0, 12, 4);
    chk("run2_state", 32'(state_o), 32'h1);
    btn_stop = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick();
      seen = m_pend[2];
    end
    chk("stop_pulse_seen", 32'(seen), 32'd1);
    force_halt = 1'b1;
    tick();
    force_halt = 1'b0;
    btn_stop = 1'b1;
    repeat (8) tick();
    chk("halt_state", 32'(state_o), 32'h3);
    chk("halt_flag", 32'(halted), 32'd1);
    press(0, 12, 8);
    chk("halt_ignores_run", 32'(state_o), 32'h3);
    press(1, 12, 8);
    chk("halt_ignores_step", 32'(state_o), 32'h3);
    press(2, 12, 8);
    chk("halt_exit", 32'(state_o), 32'd0);

    // Random traffic including bounces and halts.
    do_reset();
    halt_pct = 4;
    for (int k = 0; k < 60; k++)
      press($urandom_range(0, 2), $urandom_range(1, 12), $urandom_range(0, 10));
    halt_pct = 0;

    // Counter wrap: run starts at edge 7, edges 8..23 add 16.
    do_reset();
    press(0, 20, 0);
    repeat (3) tick();
    chk("wrap_state", 32'(state_o), 32'h1);
    chk("wrap_cnt", 32'(cycle_cnt), 32'd0);

    // Button held through reset: pulse after DEB+2, RUN one cycle later.
    btn_run = 1'b0;
    do_reset();
    repeat (DEB + 2) tick();
    chk("held_rst_wait", 32'(state_o), 32'd0);
    tick();
    chk("held_rst_run", 32'(state_o), 32'h1);
    btn_run = 1'b1;
    press(2, 10, 8);
    chk("held_rst_stop", 32'(state_o), 32'd0);

`ifdef BREAKPOINT_EN
    do_reset();
    bp_valid = 1'b1;
    press(0, 10, 0);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      seen = (m_mode == M_IDLE);
    end
    chk("bp_stopped", 32'(seen), 32'd1);
    chk("bp_state", 32'(state_o), 32'd0);
    chk("bp_hit_set", 32'(bp_hit), 32'd1);
    press(0, 10, 0);
    chk("bp_resume", 32'(state_o), 32'h1);
    chk("bp_hit_clr", 32'(bp_hit), 32'd0);
    repeat (5) tick();
    press(2, 10, 6);
    bp_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
